// File: rtl/mdu_div_sequencer.sv
// Iterative radix-2 restoring divider for RV32M DIV/DIVU/REM/REMU with valid/ready handshake.
// Optional MDU_FAST_SPECIAL_EN: divide-by-zero and signed overflow complete directly from IDLE.
module mdu_div_sequencer #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            flush,
  input  logic            req_valid,
  output logic            req_ready,
  input  logic [1:0]      op,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  output logic            busy,
  output logic            resp_valid,
  input  logic            resp_ready,
  output logic [XLEN-1:0] result,
  output logic            div_by_zero
);

  // state  | meaning
  // IDLE   | waiting for a request; req_ready high
  // CALC   | one restoring step per cycle, XLEN cycles
  // FIX    | sign correction and special-case override, result registered
  // DONE   | result presented until resp_ready
  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_CALC = 2'd1;
  localparam logic [1:0] S_FIX  = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  localparam int CW = $clog2(XLEN);
  localparam logic [XLEN-1:0] INT_MIN = {1'b1, {(XLEN-1){1'b0}}};

  logic [1:0]      state;
  logic [CW-1:0]   count;
  logic [XLEN-1:0] rem_q;
  logic [XLEN-1:0] quot_q;
  logic [XLEN-1:0] divisor_q;
  logic [XLEN-1:0] a_raw;
  logic            is_rem;
  logic            neg_q;
  logic            neg_r;
  logic            dz_q;
  logic            ovf_q;
  logic [XLEN-1:0] result_q;
  logic            dz_out;

  logic            signed_op;
  logic            a_neg;
  logic            b_neg;
  logic [XLEN-1:0] a_mag;
  logic [XLEN-1:0] b_mag;
  logic            b_zero;
  logic            ovf_in;
  logic [XLEN:0]   shifted;
  logic [XLEN+1:0] trial;
  logic            trial_neg;
  logic [XLEN-1:0] fix_value;

  function automatic logic [XLEN-1:0] special_value(input logic rem_op, input logic dz,
                                                    input logic [XLEN-1:0] dividend);
    if (dz) special_value = rem_op ? dividend : '1;
    else    special_value = rem_op ? '0 : INT_MIN;
  endfunction

  assign req_ready   = (state == S_IDLE);
  assign busy        = (state != S_IDLE);
  assign resp_valid  = (state == S_DONE);
  assign result      = result_q;
  assign div_by_zero = dz_out;

  always_comb begin
    signed_op = ~op[0];
    a_neg     = signed_op & a[XLEN-1];
    b_neg     = signed_op & b[XLEN-1];
    a_mag     = a_neg ? ('0 - a) : a;
    b_mag     = b_neg ? ('0 - b) : b;
    b_zero    = (b == '0);
    ovf_in    = signed_op & (a == INT_MIN) & (b == '1);
  end

  // Extra guard bit on the trial subtract gives a clean borrow/sign indication.
  always_comb begin
    shifted   = {rem_q, quot_q[XLEN-1]};
    trial     = {1'b0, shifted} - {2'b00, divisor_q};
    trial_neg = trial[XLEN+1];
  end

  always_comb begin
    fix_value = '0;
    if (dz_q || ovf_q)  fix_value = special_value(is_rem, dz_q, a_raw);
    else if (is_rem)    fix_value = neg_r ? ('0 - rem_q) : rem_q;
    else                fix_value = neg_q ? ('0 - quot_q) : quot_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      count     <= '0;
      rem_q     <= '0;
      quot_q    <= '0;
      divisor_q <= '0;
      a_raw     <= '0;
      is_rem    <= 1'b0;
      neg_q     <= 1'b0;
      neg_r     <= 1'b0;
      dz_q      <= 1'b0;
      ovf_q     <= 1'b0;
      result_q  <= '0;
      dz_out    <= 1'b0;
    end else if (flush) begin
      state <= S_IDLE;
    end else begin
      case (state)
        S_IDLE: begin
          if (req_valid) begin
            count     <= CW'(XLEN-1);
            rem_q     <= '0;
            quot_q    <= a_mag;
            divisor_q <= b_mag;
            a_raw     <= a;
            is_rem    <= op[1];
            neg_q     <= a_neg ^ b_neg;
            neg_r     <= a_neg;
            dz_q      <= b_zero;
            ovf_q     <= ovf_in;
`ifdef MDU_FAST_SPECIAL_EN
            if (b_zero || ovf_in) begin
              state    <= S_DONE;
              result_q <= special_value(op[1], b_zero, a);
              dz_out   <= b_zero;
            end else begin
              state <= S_CALC;
            end
`else
            state <= S_CALC;
`endif
          end
        end
        S_CALC: begin
          rem_q  <= trial_neg ? shifted[XLEN-1:0] : trial[XLEN-1:0];
          quot_q <= {quot_q[XLEN-2:0], ~trial_neg};
          count  <= count - 1'b1;
          if (count == '0) state <= S_FIX;
        end
        S_FIX: begin
          result_q <= fix_value;
          dz_out   <= dz_q;
          state    <= S_DONE;
        end
        S_DONE: begin
          if (resp_ready) state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mdu_div_sequencer.sv
// Directed bench for mdu_div_sequencer: vector table plus flush, backpressure and reset sequences.
// Honours MDU_FAST_SPECIAL_EN for the expected latency of special-case operations.
module tb_mdu_div_sequencer;

  localparam int XLEN = 32;
  localparam int NORM_LAT = XLEN + 2;
`ifdef MDU_FAST_SPECIAL_EN
  localparam int SPEC_LAT = 1;
`else
  localparam int SPEC_LAT = XLEN + 2;
`endif

  localparam logic [1:0] OP_DIV  = 2'b00;
  localparam logic [1:0] OP_DIVU = 2'b01;
  localparam logic [1:0] OP_REM  = 2'b10;
  localparam logic [1:0] OP_REMU = 2'b11;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic            flush = 1'b0;
  logic            req_valid = 1'b0;
  logic            req_ready;
  logic [1:0]      op = 2'b00;
  logic [XLEN-1:0] a = '0;
  logic [XLEN-1:0] b = '0;
  logic            busy;
  logic            resp_valid;
  logic            resp_ready = 1'b0;
  logic [XLEN-1:0] result;
  logic            div_by_zero;

  int n_cmp = 0;
  int n_bad = 0;

  mdu_div_sequencer #(.XLEN(XLEN)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .req_valid(req_valid), .req_ready(req_ready),
    .op(op), .a(a), .b(b), .busy(busy),
    .resp_valid(resp_valid), .resp_ready(resp_ready),
    .result(result), .div_by_zero(div_by_zero)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]      op;
    logic [XLEN-1:0] a;
    logic [XLEN-1:0] b;
    logic [XLEN-1:0] res;
    logic            dz;
    logic            spec;
  } vec_t;

  vec_t vecs[16];

  task automatic chk(input string name, input logic [XLEN-1:0] act, input logic [XLEN-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Issues one op at the next edge and waits (bounded) for the response, then accepts it.
  task automatic run_op(input logic [1:0] o, input logic [XLEN-1:0] xa, input logic [XLEN-1:0] xb,
                        output logic [XLEN-1:0] r, output logic d, output int lat, output logic bz);
    op = o; a = xa; b = xb; req_valid = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0;
    lat = 1;
    bz = 1'b1;
    while (!resp_valid && lat < 200) begin
      bz &= busy;
      @(posedge clk); #1;
      lat++;
    end
    r = result;
    d = div_by_zero;
    resp_ready = 1'b1;
    @(posedge clk); #1;
    resp_ready = 1'b0;
  endtask

  initial begin
    logic [XLEN-1:0] r;
    logic d, bz, ok, seen;
    int lat;

    vecs[0]  = '{OP_DIV,  32'd100,        32'd7,          32'd14,         1'b0, 1'b0};
    vecs[1]  = '{OP_REM,  32'hFFFFFFF9,   32'd2,          32'hFFFFFFFF,   1'b0, 1'b0};
    vecs[2]  = '{OP_DIVU, 32'hFFFFFFF9,   32'd2,          32'h7FFFFFFC,   1'b0, 1'b0};
    vecs[3]  = '{OP_DIVU, 32'h00001234,   32'd0,          32'hFFFFFFFF,   1'b1, 1'b1};
    vecs[4]  = '{OP_REM,  32'h00001234,   32'd0,          32'h00001234,   1'b1, 1'b1};
    vecs[5]  = '{OP_DIV,  32'h80000000,   32'hFFFFFFFF,   32'h80000000,   1'b0, 1'b1};
    vecs[6]  = '{OP_REM,  32'h80000000,   32'hFFFFFFFF,   32'h00000000,   1'b0, 1'b1};
    vecs[7]  = '{OP_DIV,  32'h00001234,   32'd0,          32'hFFFFFFFF,   1'b1, 1'b1};
    vecs[8]  = '{OP_REMU, 32'd100,        32'd7,          32'd2,          1'b0, 1'b0};
    vecs[9]  = '{OP_DIV,  32'hFFFFFF9C,   32'd7,          32'hFFFFFFF2,   1'b0, 1'b0};
    vecs[10] = '{OP_REM,  32'hFFFFFF9C,   32'd7,          32'hFFFFFFFE,   1'b0, 1'b0};
    vecs[11] = '{OP_DIV,  32'd100,        32'hFFFFFFF9,   32'hFFFFFFF2,   1'b0, 1'b0};
    vecs[12] = '{OP_REM,  32'd100,        32'hFFFFFFF9,   32'd2,          1'b0, 1'b0};
    vecs[13] = '{OP_DIVU, 32'hFFFFFFFF,   32'd1,          32'hFFFFFFFF,   1'b0, 1'b0};
    vecs[14] = '{OP_REMU, 32'hFFFFFFFF,   32'h10,         32'h0000000F,   1'b0, 1'b0};
    vecs[15] = '{OP_DIV,  32'h80000000,   32'd2,          32'hC0000000,   1'b0, 1'b0};

    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    chk("rst_resp_valid", {31'd0, resp_valid}, 32'd0);
    chk("rst_result", result, 32'd0);
    chk("rst_dz", {31'd0, div_by_zero}, 32'd0);
    chk("rst_req_ready", {31'd0, req_ready}, 32'd1);
    chk("rst_busy", {31'd0, busy}, 32'd0);

    for (int i = 0; i < 16; i++) begin
      chk($sformatf("v%0d_req_ready", i), {31'd0, req_ready}, 32'd1);
      run_op(vecs[i].op, vecs[i].a, vecs[i].b, r, d, lat, bz);
      chk($sformatf("v%0d_result", i), r, vecs[i].res);
      chk($sformatf("v%0d_dz", i), {31'd0, d}, {31'd0, vecs[i].dz});
      chk($sformatf("v%0d_latency", i), lat, vecs[i].spec ? SPEC_LAT : NORM_LAT);
      chk($sformatf("v%0d_busy", i), {31'd0, bz}, 32'd1);
      chk($sformatf("v%0d_idle_after", i), {31'd0, req_ready}, 32'd1);
    end

    // flush in IDLE blocks the request
    op = OP_DIV; a = 32'd9; b = 32'd3; req_valid = 1'b1; flush = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0; flush = 1'b0;
    chk("flush_idle_busy", {31'd0, busy}, 32'd0);

    // flush during CALC aborts; no response ever appears
    op = OP_DIV; a = 32'd100; b = 32'd7; req_valid = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0;
    repeat (10) @(posedge clk);
    #1 flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    chk("flush_busy", {31'd0, busy}, 32'd0);
    chk("flush_req_ready", {31'd0, req_ready}, 32'd1);
    seen = 1'b0;
    for (int i = 0; i < 40; i++) begin
      seen |= resp_valid;
      @(posedge clk); #1;
    end
    chk("flush_no_resp", {31'd0, seen}, 32'd0);
    run_op(OP_DIV, 32'd9, 32'd3, r, d, lat, bz);
    chk("after_flush_result", r, 32'd3);
    chk("after_flush_latency", lat, NORM_LAT);

    // backpressure in DONE, with a competing request held
    op = OP_DIV; a = 32'd100; b = 32'd7; req_valid = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0;
    lat = 1;
    while (!resp_valid && lat < 200) begin
      @(posedge clk); #1;
      lat++;
    end
    chk("bp_latency", lat, NORM_LAT);
    op = OP_DIVU; a = 32'd1; b = 32'd1; req_valid = 1'b1;
    ok = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      ok &= resp_valid && (result == 32'd14) && !req_ready;
    end
    chk("bp_hold", {31'd0, ok}, 32'd1);
    req_valid = 1'b0;
    resp_ready = 1'b1;
    @(posedge clk); #1;
    resp_ready = 1'b0;
    chk("bp_release_ready", {31'd0, req_ready}, 32'd1);
    chk("bp_release_valid", {31'd0, resp_valid}, 32'd0);

    // reset mid-CALC clears outputs left by a previous divide-by-zero
    run_op(OP_REM, 32'h1234, 32'd0, r, d, lat, bz);
    chk("pre_rst_dz", {31'd0, d}, 32'd1);
    op = OP_DIV; a = 32'd100; b = 32'd7; req_valid = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0;
    repeat (5) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("mid_rst_result", result, 32'd0);
    chk("mid_rst_dz", {31'd0, div_by_zero}, 32'd0);
    chk("mid_rst_valid", {31'd0, resp_valid}, 32'd0);
    chk("mid_rst_busy", {31'd0, busy}, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
